// File: rtl/calc_seq_pkg.sv
// Shared types and constants for the calculator I/O sequencer: FSM states,
// status codes, operand slot numbering and the core-status mapping.
package calc_seq_pkg;

  localparam int DATA_W = 16;
  localparam int OPER_W = 32;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SHOW  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_CORE = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_PROT = 2'b11;

  localparam logic [1:0] SLOT_A_HI = 2'd0;
  localparam logic [1:0] SLOT_A_LO = 2'd1;
  localparam logic [1:0] SLOT_B_HI = 2'd2;
  localparam logic [1:0] SLOT_B_LO = 2'd3;

  // Any non-zero core status collapses to a single "core error" code.
  function automatic logic [1:0] map_core_err(input logic [1:0] status);
    return (status != 2'b00) ? ERR_CORE : ERR_OK;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Cycle-count watchdog supervising the arithmetic core handshake.
// Saturates at TIMEOUT_CYC-1 so expired stays asserted until cleared.
module seq_watchdog #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/calc_io_sequencer.sv
// Calculator I/O sequencer: gathers four switch words into two operands,
// runs the arithmetic core under a watchdog and pages through the result.
module calc_io_sequencer
  import calc_seq_pkg::*;
#(
  parameter int RES_WORDS   = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13,
  localparam int PAGE_W     = $clog2(RES_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_stb,
  input  logic                        nxt_stb,
  input  logic                        clr_stb,
  input  logic [DATA_W-1:0]           data_in,
  output logic [OPER_W-1:0]           op_a,
  output logic [OPER_W-1:0]           op_b,
  output logic                        calc_start,
  output logic                        calc_abort,
  input  logic                        calc_done,
  input  logic [1:0]                  calc_err,
  input  logic [DATA_W*RES_WORDS-1:0] calc_result,
  output logic [DATA_W-1:0]           disp_word,
  output logic [PAGE_W-1:0]           disp_page,
  output logic                        busy,
  output logic [1:0]                  err
);

  localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(RES_WORDS - 1);

  if (RES_WORDS < 2) begin : g_bad_res_words
    $error("calc_io_sequencer: RES_WORDS must be at least 2");
  end
  if ((2 ** CNT_W) <= TIMEOUT_CYC) begin : g_bad_cnt_w
    $error("calc_io_sequencer: CNT_W too narrow for TIMEOUT_CYC");
  end

  state_t                      state;
  state_t                      state_nxt;
  logic [1:0]                  word_idx;
  logic [DATA_W*RES_WORDS-1:0] result_q;
  logic [DATA_W-1:0]           res_words [RES_WORDS];
  logic                        expired;
  logic                        wd_clear;
  logic                        wd_enable;
  logic                        start_d;
  logic                        abort_d;
  logic                        busy_d;

  assign wd_clear  = clr_stb || (state == ST_START);
  assign wd_enable = (state == ST_WAIT);

  seq_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (expired)
  );

  // Word 0 sits in the most significant bits of the result bus.
  for (genvar i = 0; i < RES_WORDS; i++) begin : g_words
    assign res_words[i] = result_q[DATA_W*(RES_WORDS-1-i) +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr_stb) begin
      state_nxt = ST_LOAD;
    end else begin
      case (state)
        ST_LOAD:  if (in_stb && (word_idx == SLOT_B_LO)) state_nxt = ST_START;
        ST_START: state_nxt = ST_WAIT;
        ST_WAIT:  if (calc_done || expired) state_nxt = ST_SHOW;
        default:  state_nxt = state;
      endcase
    end
  end

  // Control outputs are computed one cycle early and registered below.
  always_comb begin
    start_d = (state_nxt == ST_START) && (state == ST_LOAD);
    busy_d  = (state_nxt == ST_START) || (state_nxt == ST_WAIT);
    abort_d = (state == ST_WAIT) && (clr_stb || (expired && !calc_done));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calc_start <= 1'b0;
      calc_abort <= 1'b0;
      busy       <= 1'b0;
    end else begin
      calc_start <= start_d;
      calc_abort <= abort_d;
      busy       <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx  <= SLOT_A_HI;
      op_a      <= '0;
      op_b      <= '0;
      result_q  <= '0;
      disp_word <= '0;
      disp_page <= '0;
      err       <= ERR_OK;
    end else if (clr_stb) begin
      word_idx  <= SLOT_A_HI;
      op_a      <= '0;
      op_b      <= '0;
      result_q  <= '0;
      disp_word <= '0;
      disp_page <= '0;
      err       <= ERR_OK;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_stb) begin
            case (word_idx)
              SLOT_A_HI: op_a[31:16] <= data_in;
              SLOT_A_LO: op_a[15:0]  <= data_in;
              SLOT_B_HI: op_b[31:16] <= data_in;
              default:   op_b[15:0]  <= data_in;
            endcase
            word_idx <= word_idx + 1'b1;
          end
          if (nxt_stb) err <= ERR_PROT;
        end
        ST_START: err <= ERR_OK;
        ST_WAIT: begin
          if (calc_done) begin
            result_q  <= calc_result;
            err       <= map_core_err(calc_err);
            disp_page <= '0;
          end else if (expired) begin
            result_q  <= '0;
            err       <= ERR_TMO;
            disp_page <= '0;
          end
        end
        default: begin
          if (nxt_stb) begin
            disp_page <= (disp_page == LAST_PAGE) ? '0 : disp_page + 1'b1;
          end
        end
      endcase
      disp_word <= res_words[disp_page];
    end
  end

endmodule
